// File: rtl/gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_branch_predictor
// Description : gshare direction predictor with a tagged branch target buffer.
//               Registered one-cycle prediction for fetch and commit-time
//               training with speculative global-history repair.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_branch_predictor #(
    parameter int PHT_ENTRIES = 256,
    parameter int CNT_W       = 2,
    parameter int HIST_W      = 8,
    parameter int BTB_ENTRIES = 64
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              query_valid,
    input  logic [31:0]       query_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_mispredict
);

    localparam int c_IDX_W  = $clog2(PHT_ENTRIES);
    localparam int c_BIDX_W = $clog2(BTB_ENTRIES);
    localparam int c_TAG_W  = 32 - c_BIDX_W - 2;
    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0]   r_cnt_q       [PHT_ENTRIES];
    logic               r_btb_valid_q [BTB_ENTRIES];
    logic [c_TAG_W-1:0] r_btb_tag_q   [BTB_ENTRIES];
    logic [31:0]        r_btb_tgt_q   [BTB_ENTRIES];

    logic [HIST_W-1:0]  r_ghr_q, w_ghr_d;
    logic               r_pred_valid_q, w_pred_valid_d;
    logic               r_pred_taken_q, w_pred_taken_d;
    logic [31:0]        r_pred_target_q, w_pred_target_d;
    logic [HIST_W-1:0]  r_pred_ghr_q, w_pred_ghr_d;

    logic [c_IDX_W-1:0]  w_pidx, w_uidx;
    logic [c_BIDX_W-1:0] w_qslot, w_uslot;
    logic [c_TAG_W-1:0]  w_qtag, w_utag;
    logic                w_btb_hit;
    logic                w_query_taken;
    logic [CNT_W-1:0]    w_ucnt, w_ucnt_new;
    logic [HIST_W-1:0]   w_spec_ghr, w_rep_ghr;
    logic                w_unused;

    assign w_unused = ^upd_pc[1:0];

    assign w_pidx  = query_pc[c_IDX_W+1:2] ^ c_IDX_W'(r_ghr_q);
    assign w_uidx  = upd_pc[c_IDX_W+1:2] ^ c_IDX_W'(upd_ghr);
    assign w_qslot = query_pc[c_BIDX_W+1:2];
    assign w_uslot = upd_pc[c_BIDX_W+1:2];
    assign w_qtag  = query_pc[31:c_BIDX_W+2];
    assign w_utag  = upd_pc[31:c_BIDX_W+2];

    // A BTB miss forces not-taken so a taken prediction always has a target.
    assign w_btb_hit     = r_btb_valid_q[w_qslot] && (r_btb_tag_q[w_qslot] == w_qtag);
    assign w_query_taken = r_cnt_q[w_pidx][CNT_W-1] && w_btb_hit;

    generate
        if (HIST_W == 1) begin : g_hist_one
            assign w_spec_ghr = w_query_taken;
            assign w_rep_ghr  = upd_taken;
        end else begin : g_hist_multi
            assign w_spec_ghr = {r_ghr_q[HIST_W-2:0], w_query_taken};
            assign w_rep_ghr  = {upd_ghr[HIST_W-2:0], upd_taken};
        end
    endgenerate

    always_comb begin
        w_ucnt     = r_cnt_q[w_uidx];
        w_ucnt_new = w_ucnt;
        if (upd_taken) begin
            if (w_ucnt != c_CNT_MAX) w_ucnt_new = w_ucnt + 1'b1;
        end else begin
            if (w_ucnt != '0) w_ucnt_new = w_ucnt - 1'b1;
        end
    end

    always_comb begin
        w_ghr_d         = r_ghr_q;
        w_pred_valid_d  = r_pred_valid_q;
        w_pred_taken_d  = r_pred_taken_q;
        w_pred_target_d = r_pred_target_q;
        w_pred_ghr_d    = r_pred_ghr_q;
        if (rdy_in) begin
            w_pred_valid_d = query_valid;
            if (query_valid) begin
                w_pred_taken_d  = w_query_taken;
                w_pred_target_d = w_query_taken ? r_btb_tgt_q[w_qslot] : query_pc + 32'd4;
                w_pred_ghr_d    = r_ghr_q;
                w_ghr_d         = w_spec_ghr;
            end
            // Repair from commit overrides any speculative shift this cycle.
            if (upd_valid && upd_mispredict) w_ghr_d = w_rep_ghr;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_ghr_q         <= '0;
            r_pred_valid_q  <= 1'b0;
            r_pred_taken_q  <= 1'b0;
            r_pred_target_q <= '0;
            r_pred_ghr_q    <= '0;
        end else begin
            r_ghr_q         <= w_ghr_d;
            r_pred_valid_q  <= w_pred_valid_d;
            r_pred_taken_q  <= w_pred_taken_d;
            r_pred_target_q <= w_pred_target_d;
            r_pred_ghr_q    <= w_pred_ghr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < PHT_ENTRIES; i++) r_cnt_q[i] <= c_CNT_INIT;
        end else if (rdy_in && upd_valid) begin
            r_cnt_q[w_uidx] <= w_ucnt_new;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BTB_ENTRIES; i++) r_btb_valid_q[i] <= 1'b0;
        end else if (rdy_in && upd_valid && upd_taken) begin
            r_btb_valid_q[w_uslot] <= 1'b1;
        end
    end

    // Tag/target storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && upd_valid && upd_taken) begin
            r_btb_tag_q[w_uslot] <= w_utag;
            r_btb_tgt_q[w_uslot] <= upd_target;
        end
    end

    assign pred_valid  = r_pred_valid_q;
    assign pred_taken  = r_pred_taken_q;
    assign pred_target = r_pred_target_q;
    assign pred_ghr    = r_pred_ghr_q;

endmodule
`default_nettype wire

// File: tb/tb_gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_branch_predictor
// Description : Directed scoreboard bench for gshare_branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_branch_predictor;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, query_valid;
    logic [31:0] query_pc;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        upd_valid, upd_taken, upd_mispredict;
    logic [31:0] upd_pc, upd_target;
    logic [7:0]  upd_ghr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [7:0]  ghr;
    } exp_t;
    exp_t sb[$];

    gshare_branch_predictor #(
        .PHT_ENTRIES(256), .CNT_W(2), .HIST_W(8), .BTB_ENTRIES(64)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .query_valid(query_valid), .query_pc(query_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict)
    );

    always #5 clk_in = ~clk_in;

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pred();
        exp_t e;
        if (sb.size() == 0) begin
            check("pred_valid_idle", 32'(pred_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            check("pred_valid", 32'(pred_valid), 32'd1);
            check("pred_taken", 32'(pred_taken), 32'(e.taken));
            check("pred_target", pred_target, e.target);
            check("pred_ghr", 32'(pred_ghr), 32'(e.ghr));
        end
    endtask

    task automatic query(input logic [31:0] pc, input logic et,
                         input logic [31:0] etgt, input logic [7:0] eghr);
        query_valid = 1'b1;
        query_pc    = pc;
        sb.push_back('{taken: et, target: etgt, ghr: eghr});
        cycle();
        query_valid = 1'b0;
        check_pred();
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [7:0] gh, input logic t,
                           input logic [31:0] tgt, input logic mp);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_ghr        = gh;
        upd_taken      = t;
        upd_target     = tgt;
        upd_mispredict = mp;
    endtask

    task automatic clr_upd();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [7:0] gh, input logic t,
                       input logic [31:0] tgt, input logic mp);
        set_upd(pc, gh, t, tgt, mp);
        cycle();
        clr_upd();
        check_pred();
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; query_valid = 1'b0; query_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0;
        cycle(); cycle();
        check("rst_pred_valid", 32'(pred_valid), 32'd0);
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        check("rst_pred_target", pred_target, 32'd0);
        check("rst_pred_ghr", 32'(pred_ghr), 32'd0);
        rst_in = 1'b1;

        // Cold query: weakly not-taken, BTB empty
        query(32'h100, 1'b0, 32'h104, 8'h00);

        // Train 0x200 taken twice, then repair history to zero
        upd(32'h200, 8'h00, 1'b1, 32'h300, 1'b0);
        upd(32'h200, 8'h00, 1'b1, 32'h300, 1'b0);
        upd(32'h1F0, 8'h00, 1'b0, 32'h0, 1'b1);
        query(32'h200, 1'b1, 32'h300, 8'h00);

        // Saturation: counter at 3 stays 3, one not-taken -> 2 still taken
        for (int i = 0; i < 5; i++) upd(32'h200, 8'h00, 1'b1, 32'h300, 1'b0);
        upd(32'h200, 8'h00, 1'b0, 32'h0, 1'b1);
        query(32'h200, 1'b1, 32'h300, 8'h00);
        upd(32'h200, 8'h00, 1'b0, 32'h0, 1'b1);
        query(32'h200, 1'b0, 32'h204, 8'h00);

        // Tag alias: 0x300 evicts 0x200 from BTB slot 0
        upd(32'h200, 8'h00, 1'b1, 32'h300, 1'b0);
        upd(32'h300, 8'h00, 1'b1, 32'h500, 1'b0);
        query(32'h200, 1'b0, 32'h204, 8'h00);
        query(32'h300, 1'b1, 32'h500, 8'h00);

        // Set ghr to 0x05, then query concurrent with mispredict repair
        upd(32'h1040, 8'h02, 1'b1, 32'h2000, 1'b1);
        set_upd(32'h1080, 8'h3C, 1'b1, 32'h3000, 1'b1);
        query(32'h400, 1'b0, 32'h404, 8'h05);
        clr_upd();
        query(32'h800, 1'b0, 32'h804, 8'h79);

        // Stall: outputs and ghr frozen while rdy_in is low
        query(32'hC00, 1'b0, 32'hC04, 8'hF2);
        rdy_in = 1'b0;
        query_valid = 1'b1; query_pc = 32'h100;
        set_upd(32'h1100, 8'hAA, 1'b1, 32'h4000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_valid", 32'(pred_valid), 32'd1);
            check("stall_target", pred_target, 32'hC04);
            check("stall_ghr", 32'(pred_ghr), 32'hF2);
        end
        query_valid = 1'b0;
        clr_upd();
        rdy_in = 1'b1;
        cycle();
        check_pred();
        query(32'h000, 1'b0, 32'h004, 8'hE4);

        // Reset with a query in flight: dropped, all state cleared
        query_valid = 1'b1; query_pc = 32'h100;
        rst_in = 1'b0;
        cycle();
        query_valid = 1'b0;
        rst_in = 1'b1;
        check("rst_drop_valid", 32'(pred_valid), 32'd0);
        check("rst_drop_target", pred_target, 32'd0);
        check("rst_drop_ghr", 32'(pred_ghr), 32'd0);
        query(32'h200, 1'b0, 32'h204, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
